// File: rtl/proc_io_pkg.sv
// Shared types and constants for the processor IO output path.
// io_entry_t is sized for the default NUBITS=16 / NUIOOU=8 configuration.
package proc_io_pkg;

    localparam int NUBITS_DEF = 16;
    localparam int NUIOOU_DEF = 8;
    localparam int NBADDR_DEF = $clog2(NUIOOU_DEF);
    localparam int DROPCNT_W  = 16;

    typedef struct packed {
        logic [NBADDR_DEF-1:0] addr;
        logic [NUBITS_DEF-1:0] data;
    } io_entry_t;

    // Packed {addr,data} width for an arbitrary configuration.
    function automatic int entry_width(input int nubits, input int nuioou);
        return nubits + $clog2(nuioou);
    endfunction

endpackage

// File: rtl/io_out_fifo_if.sv
// Processor-write side and valid/ready drain side of io_out_fifo.
// The slave modport is the FIFO's view; master is the producer/consumer view.
interface io_out_fifo_if #(
    parameter int NUBITS = 16,
    parameter int NBADDR = 3
);
    logic [NUBITS-1:0] io_out;
    logic [NBADDR-1:0] addr_out;
    logic              out_en;
    logic [NUBITS-1:0] m_data;
    logic [NBADDR-1:0] m_addr;
    logic              m_valid;
    logic              m_ready;

    modport slave  (input  io_out, addr_out, out_en, m_ready,
                    output m_data, m_addr, m_valid);
    modport master (output io_out, addr_out, out_en, m_ready,
                    input  m_data, m_addr, m_valid);
endinterface

// File: rtl/fifo_sync_fx.sv
// Generic single-clock show-ahead FIFO: head word is visible on rdata whenever
// not empty; a push into a full FIFO is accepted only when a pop frees a slot.
module fifo_sync_fx #(
    parameter  int WIDTH = 19,
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    // Storage is never reset; an empty FIFO presents zero on its head.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        level_d  = level_q;
        if (push_ok && !pop_ok)
            level_d = level_q + LW'(1);
        else if (pop_ok && !push_ok)
            level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/io_out_fifo.sv
// Buffers processor OUT writes as {addr,data} entries and drains them to a
// valid/ready stream. Optional IO_OUT_FIFO_DROPCNT_EN adds a saturating drop counter.
import proc_io_pkg::*;

module io_out_fifo #(
    parameter  int                NUBITS  = 16,
    parameter  int                NUIOOU  = 8,
    parameter  int                FDEPTH  = 16,
    parameter  logic [NUIOOU-1:0] PORTMSK = {NUIOOU{1'b1}},
    localparam int                NBADDR  = $clog2(NUIOOU),
    localparam int                NBLVL   = $clog2(FDEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    io_out_fifo_if.slave         bus,
    output logic [NBLVL-1:0]     level,
    output logic                 ovf,
`ifdef IO_OUT_FIFO_DROPCNT_EN
    output logic [DROPCNT_W-1:0] drop_cnt,
`endif
    input  logic                 ovf_clr
);

    localparam int EW = entry_width(NUBITS, NUIOOU);

    logic          push, pop, drop, port_en;
    logic          fifo_full, fifo_empty;
    logic [EW-1:0] wdata, rdata;
    logic          ovf_q, ovf_d;

    // Addresses beyond NUIOOU match no mask bit and are therefore ignored.
    always_comb begin
        port_en = 1'b0;
        for (int i = 0; i < NUIOOU; i++)
            if (int'(bus.addr_out) == i) port_en = PORTMSK[i];
    end

    assign push  = bus.out_en & port_en;
    assign pop   = bus.m_valid & bus.m_ready;
    assign drop  = push & fifo_full & ~pop;
    assign wdata = {bus.addr_out, bus.io_out};

    fifo_sync_fx #(
        .WIDTH (EW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign {bus.m_addr, bus.m_data} = rdata;
    assign bus.m_valid = ~fifo_empty;

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;

`ifdef IO_OUT_FIFO_DROPCNT_EN
    logic [DROPCNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr)
            drop_cnt_d = DROPCNT_W'(drop);
        else if (drop && drop_cnt_q != '1)
            drop_cnt_d = drop_cnt_q + DROPCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_io_out_fifo.sv
// Self-checking bench for io_out_fifo: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_io_out_fifo;
    import proc_io_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] level, level_m;
    logic       ovf, ovf_m, ovf_clr, ovf_clr_m;
`ifdef IO_OUT_FIFO_DROPCNT_EN
    logic [15:0] drop_cnt, drop_cnt_m;
`endif

    always #5 clk = ~clk;

    io_out_fifo_if #(.NUBITS(16), .NBADDR(3)) bus ();
    io_out_fifo_if #(.NUBITS(16), .NBADDR(3)) bus_m ();

    io_out_fifo #(.NUBITS(16), .NUIOOU(8), .FDEPTH(16), .PORTMSK(8'hFF)) dut (
        .clk(clk), .rst(rst), .bus(bus), .level(level), .ovf(ovf),
`ifdef IO_OUT_FIFO_DROPCNT_EN
        .drop_cnt(drop_cnt),
`endif
        .ovf_clr(ovf_clr)
    );

    io_out_fifo #(.NUBITS(16), .NUIOOU(8), .FDEPTH(16), .PORTMSK(8'b0000_0001)) dut_m (
        .clk(clk), .rst(rst), .bus(bus_m), .level(level_m), .ovf(ovf_m),
`ifdef IO_OUT_FIFO_DROPCNT_EN
        .drop_cnt(drop_cnt_m),
`endif
        .ovf_clr(ovf_clr_m)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: queue of pending entries plus overflow bookkeeping.
    io_entry_t mq[$];
    bit        movf;
    int        mdrop;

    typedef struct {
        bit          en;
        logic [2:0]  addr;
        logic [15:0] data;
        bit          rdy;
        bit          ev;
        logic [2:0]  ea;
        logic [15:0] ed;
        int          elvl;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit e, input logic [2:0] a, input logic [15:0] d,
                       input bit r, input bit c);
        bus.out_en = e; bus.addr_out = a; bus.io_out = d; bus.m_ready = r; ovf_clr = c;
        @(posedge clk); #1;
        bus.out_en = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic cyc_m(input bit e, input logic [2:0] a, input logic [15:0] d, input bit r);
        bus_m.out_en = e; bus_m.addr_out = a; bus_m.io_out = d; bus_m.m_ready = r;
        @(posedge clk); #1;
        bus_m.out_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        mq.delete(); movf = 1'b0; mdrop = 0;
    endtask

    // Model: a pop frees a slot first, so a push fits iff the queue then has room.
    task automatic mstep(input bit e, input logic [2:0] a, input logic [15:0] d,
                         input bit r, input bit c);
        io_entry_t ent;
        bit drop = 1'b0;
        if (r && mq.size() > 0) void'(mq.pop_front());
        if (e) begin
            if (mq.size() < 16) begin
                ent.addr = a; ent.data = d;
                mq.push_back(ent);
            end else drop = 1'b1;
        end
        movf = drop ? 1'b1 : (c ? 1'b0 : movf);
        if (c) mdrop = drop ? 1 : 0;
        else if (drop && mdrop < 65535) mdrop++;
    endtask

    task automatic mcheck();
        chk("rnd_valid", bus.m_valid, mq.size() > 0);
        chk("rnd_level", level, mq.size());
        chk("rnd_ovf", ovf, movf);
        if (mq.size() > 0) begin
            chk("rnd_data", bus.m_data, mq[0].data);
            chk("rnd_addr", bus.m_addr, mq[0].addr);
        end
`ifdef IO_OUT_FIFO_DROPCNT_EN
        chk("rnd_dropcnt", drop_cnt, mdrop);
`endif
    endtask

    initial begin
        bus.out_en = 0; bus.addr_out = 0; bus.io_out = 0; bus.m_ready = 0; ovf_clr = 0;
        bus_m.out_en = 0; bus_m.addr_out = 0; bus_m.io_out = 0; bus_m.m_ready = 0; ovf_clr_m = 0;
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;

        chk("rst_valid", bus.m_valid, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_addr", bus.m_addr, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_m_valid", bus_m.m_valid, 0);
`ifdef IO_OUT_FIFO_DROPCNT_EN
        chk("rst_dropcnt", drop_cnt, 0);
`endif

        // Single write, held head, push+pop, ready on empty.
        tbl[0] = '{1, 3, 16'h1234, 1, 1, 3, 16'h1234, 1};
        tbl[1] = '{0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0};
        tbl[2] = '{1, 7, 16'hBEEF, 0, 1, 7, 16'hBEEF, 1};
        tbl[3] = '{1, 0, 16'h0001, 0, 1, 7, 16'hBEEF, 2};
        tbl[4] = '{0, 0, 16'h0000, 1, 1, 0, 16'h0001, 1};
        tbl[5] = '{1, 2, 16'h2222, 1, 1, 2, 16'h2222, 1};
        tbl[6] = '{0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0};
        tbl[7] = '{0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0};
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].en, tbl[i].addr, tbl[i].data, tbl[i].rdy, 0);
            chk($sformatf("vec%0d_valid", i), bus.m_valid, tbl[i].ev);
            chk($sformatf("vec%0d_level", i), level, tbl[i].elvl);
            chk($sformatf("vec%0d_ovf", i), ovf, 0);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_addr", i), bus.m_addr, tbl[i].ea);
                chk($sformatf("vec%0d_data", i), bus.m_data, tbl[i].ed);
            end
        end

        // Backpressure fill, overflow drop, ordered drain.
        for (int i = 0; i < 16; i++) cyc(1, 3'(i), 16'(i), 0, 0);
        chk("bp_level16", level, 16);
        chk("bp_head0", bus.m_data, 0);
        chk("bp_ovf0", ovf, 0);
        cyc(1, 0, 16'd99, 0, 0);
        chk("bp_drop_level", level, 16);
        chk("bp_drop_ovf", ovf, 1);
        chk("bp_drop_head", bus.m_data, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("bp_drain%0d_valid", i), bus.m_valid, 1);
            chk($sformatf("bp_drain%0d_data", i), bus.m_data, i);
            cyc(0, 0, 0, 1, 0);
        end
        chk("bp_empty_valid", bus.m_valid, 0);
        chk("bp_empty_level", level, 0);
        chk("bp_ovf_sticky", ovf, 1);
        cyc(0, 0, 0, 1, 1);
        chk("bp_ovf_clr", ovf, 0);

        // Full with same-cycle push and pop.
        for (int i = 0; i < 16; i++) cyc(1, 3'(i), 16'(100 + i), 0, 0);
        cyc(1, 2, 16'hAAAA, 1, 0);
        chk("fpp_level", level, 16);
        chk("fpp_ovf", ovf, 0);
        chk("fpp_head", bus.m_data, 101);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("fpp_drain%0d", i), bus.m_data, 100 + i);
            cyc(0, 0, 0, 1, 0);
        end
        chk("fpp_last_data", bus.m_data, 16'hAAAA);
        chk("fpp_last_addr", bus.m_addr, 2);
        cyc(0, 0, 0, 1, 0);
        chk("fpp_final_level", level, 0);

        // Port mask on the second instance.
        cyc_m(1, 0, 16'h0A0A, 0);
        cyc_m(1, 5, 16'h5555, 0);
        chk("msk_level", level_m, 1);
        chk("msk_addr", bus_m.m_addr, 0);
        chk("msk_data", bus_m.m_data, 16'h0A0A);
        cyc_m(0, 0, 0, 1);
        chk("msk_empty", bus_m.m_valid, 0);
        for (int i = 0; i < 20; i++) cyc_m(1, 3'(1 + i % 7), 16'(i), 0);
        chk("msk_masked_level", level_m, 0);
        chk("msk_ovf", ovf_m, 0);

        // Reset mid-stream, with ovf set beforehand.
        for (int i = 0; i < 17; i++) cyc(1, 3'(i), 16'(i + 1), 0, 0);
        chk("rms_level_pre", level, 16);
        chk("rms_ovf_pre", ovf, 1);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rms_valid", bus.m_valid, 0);
        chk("rms_level", level, 0);
        chk("rms_ovf", ovf, 0);
        cyc(1, 1, 16'h0042, 0, 0);
        chk("rms_new_valid", bus.m_valid, 1);
        chk("rms_new_data", bus.m_data, 16'h0042);
        chk("rms_new_level", level, 1);
        cyc(0, 0, 0, 1, 0);
        chk("rms_alone", bus.m_valid, 0);

`ifdef IO_OUT_FIFO_DROPCNT_EN
        for (int i = 0; i < 16; i++) cyc(1, 0, 16'(i), 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 16'hDEAD, 0, 0);
        chk("dc_three", drop_cnt, 3);
        cyc(1, 0, 16'hDEAD, 0, 1);
        chk("dc_clr_drop_ovf", ovf, 1);
        chk("dc_clr_drop_cnt", drop_cnt, 1);
        cyc(0, 0, 0, 0, 1);
        chk("dc_clr_ovf", ovf, 0);
        chk("dc_clr_cnt", drop_cnt, 0);
`endif

        // Randomized run against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bit          e, r, c;
            logic [2:0]  a;
            logic [15:0] d;
            int          rp;
            rp = (k < 1000) ? 20 : (k < 2000) ? 90 : 50;
            e  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 99) < rp);
            c  = ($urandom_range(0, 63) == 0);
            a  = 3'($urandom);
            d  = 16'($urandom);
            mstep(e, a, d, r, c);
            cyc(e, a, d, r, c);
            mcheck();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
